// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default sizing constants
// common to the PWM generator and the PWM capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } cap_state_e;

  localparam int PWM_CNT_W       = 16;
  localparam int PWM_TIMEOUT_CYC = 1024;
  localparam int PWM_SYNC_STAGES = 2;
  localparam int PWM_FILT_LEN    = 3;

endpackage

// File: rtl/pwm_sync_edge.sv
// Input front end for pwm_capture: synchronizer, optional glitch filter
// (PWM_CAPTURE_FILTER_EN), previous-level flop and rise/fall detection.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILT_LEN = 3
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   lvl;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCNT_W = $clog2(FILT_LEN + 1);

  logic [FCNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              filt_lvl_q, filt_lvl_d;

  // Count consecutive cycles that disagree with the filtered level; any
  // agreeing cycle restarts the count, so short glitches never get through.
  always_comb begin
    filt_cnt_d = '0;
    filt_lvl_d = filt_lvl_q;
    if (synced != filt_lvl_q) begin
      if (filt_cnt_q == FCNT_W'(FILT_LEN - 1)) begin
        filt_lvl_d = synced;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_cnt_q <= '0;
      filt_lvl_q <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      filt_lvl_q <= filt_lvl_d;
    end
  end

  assign lvl = filt_lvl_q;
`else
  assign lvl = synced;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl;
    end
  end

  assign lvl_o  = lvl;
  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of pwm_in in clk
// cycles, with stuck-high/low timeout flags. Glitch filter via PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = PWM_SYNC_STAGES,
  parameter int TIMEOUT_CYC = PWM_TIMEOUT_CYC
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILT_LEN  = PWM_FILT_LEN
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT_CYC - 1);

  logic lvl, rise, fall, timeout;

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] hi_hold_q, hi_hold_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_hi_q, stuck_hi_d;
  logic             stuck_lo_q, stuck_lo_d;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
    , .FILT_LEN(FILT_LEN)
`endif
  ) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .lvl_o (lvl),
    .rise_o(rise),
    .fall_o(fall)
  );

  // Timeout fires on the cycle the run counter steps onto TIMEOUT_CYC, so a
  // saturated counter raises each flag only once per silent stretch.
  assign timeout = (state_q != IDLE) && !rise && (run_cnt_q == TMO_M1);

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    hi_hold_d  = hi_hold_q;
    high_d     = high_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;

    if (!enable) begin
      state_d    = IDLE;
      run_cnt_d  = '0;
      stuck_hi_d = 1'b0;
      stuck_lo_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d   = WAIT_RISE;
      run_cnt_d = '0;
    end else begin
      if (rise) begin
        run_cnt_d = CNT_W'(1);
      end else if (run_cnt_q < TMO) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end

      case (state_q)
        WAIT_RISE: if (rise) state_d = MEAS_HIGH;
        MEAS_HIGH: begin
          if (fall) begin
            state_d   = MEAS_LOW;
            hi_hold_d = run_cnt_q;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            state_d    = MEAS_HIGH;
            high_d     = hi_hold_q;
            period_d   = run_cnt_q;
            valid_d    = 1'b1;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase

      // A timeout abandons the measurement in progress; results keep their last values.
      if (timeout) begin
        state_d = WAIT_RISE;
        if (lvl) stuck_hi_d = 1'b1;
        else     stuck_lo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      hi_hold_q  <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      hi_hold_q  <= hi_hold_d;
      high_q     <= high_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign meas_valid = valid_q;
  assign stuck_high = stuck_hi_q;
  assign stuck_low  = stuck_lo_q;

endmodule
